// File: rtl/agc_clk_pkg.sv
// Shared types and constants for the burst clock scheduler: FSM encoding,
// requester indices, default widths and the round-robin pick helper.
package agc_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    // ptr names the requester that wins a tie.
    function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
        if (req[REQ_A] && req[REQ_B])
            return ptr;
        else if (req[REQ_B])
            return REQ_B;
        else
            return REQ_A;
    endfunction

endpackage

// File: rtl/agc_div_core.sv
// Half-period counter and divided-clock toggle flop. clr overrides en and
// parks the output low; pulses flag the edge at which clk_out will toggle.
module agc_div_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] div_half,
    output logic             clk_out,
    output logic             fall_pulse,
    output logic             rise_pulse
);

    logic [WIDTH-1:0] half_cnt;
    logic [WIDTH-1:0] div_m1;
    logic             wrap;

    // A divisor of zero behaves as one: toggle every cycle.
    assign div_m1 = (div_half == '0) ? '0 : div_half - 1'b1;
    assign wrap   = en && !clr && (half_cnt == div_m1);

    assign fall_pulse = wrap && clk_out;
    assign rise_pulse = wrap && !clk_out;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            half_cnt <= '0;
            clk_out  <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                half_cnt <= '0;
                clk_out  <= ~clk_out;
            end else begin
                half_cnt <= half_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/agc_clk_sched.sv
// Two-requester round-robin scheduler that emits a gated, divided clock burst
// of a latched length and half-period for the granted requester.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for req; arbitrate, latch winner's settings
//   LOAD  | one cycle; counters cleared, clk_out held low
//   RUN   | divided clock running until the pulse count is reached
//   DONE  | one cycle; done pulse, grant released, pointer advanced
module agc_clk_sched
    import agc_clk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] div_half_a,
    input  logic [WIDTH-1:0] div_half_b,
    input  logic [CNT_W-1:0] burst_len_a,
    input  logic [CNT_W-1:0] burst_len_b,
    input  logic             abort,
    output logic [1:0]       gnt,
    output logic             clk_out,
    output logic             csgo,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    state_t           state;
    logic             rr_ptr;
    logic             served;
    logic             win;
    logic [WIDTH-1:0] div_lat;
    logic [CNT_W-1:0] len_lat;
    logic [CNT_W-1:0] pulse_cnt;
    logic             run_abort;
    logic             burst_end;
    logic             div_en;
    logic             div_clr;
    logic             fall_pulse;
    logic             rise_pulse;

    assign win       = rr_pick(req, rr_ptr);
    assign run_abort = abort && ((state == ST_LOAD) || (state == ST_RUN));
    assign burst_end = (state == ST_RUN) && (pulse_cnt == len_lat);
    // Counting stops once the last falling edge has landed so a fast divisor
    // cannot re-raise clk_out during the closing RUN cycle.
    assign div_en    = (state == ST_RUN) && !burst_end;
    assign div_clr   = (state != ST_RUN) || run_abort;

    agc_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .en         (div_en),
        .clr        (div_clr),
        .div_half   (div_lat),
        .clk_out    (clk_out),
        .fall_pulse (fall_pulse),
        .rise_pulse (rise_pulse)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            csgo      <= 1'b0;
            rr_ptr    <= REQ_A;
            served    <= REQ_A;
            div_lat   <= '0;
            len_lat   <= '0;
            pulse_cnt <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            csgo    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        served  <= win;
                        gnt     <= (win == REQ_B) ? 2'b10 : 2'b01;
                        div_lat <= (win == REQ_B) ? div_half_b : div_half_a;
                        len_lat <= (win == REQ_B) ? burst_len_b : burst_len_a;
                        busy    <= 1'b1;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    pulse_cnt <= '0;
                    if (run_abort) begin
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        state   <= ST_DONE;
                    end else if (len_lat == '0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (run_abort) begin
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        state   <= ST_DONE;
                    end else if (burst_end) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        if (fall_pulse)
                            pulse_cnt <= pulse_cnt + 1'b1;
                        if (rise_pulse && (pulse_cnt == '0))
                            csgo <= 1'b1;
                    end
                end
                ST_DONE: begin
                    gnt    <= 2'b00;
                    rr_ptr <= ~served;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_agc_clk_sched.sv
// Directed bench for agc_clk_sched: per-cycle capture of outputs after each
// request, compared against hand-derived cycle numbers.
module tb_agc_clk_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] div_half_a = 8'd1;
    logic [7:0] div_half_b = 8'd1;
    logic [7:0] burst_len_a = 8'd1;
    logic [7:0] burst_len_b = 8'd1;
    logic       abort = 1'b0;
    logic [1:0] gnt;
    logic       clk_out;
    logic       csgo;
    logic       busy;
    logic       done;
    logic       aborted;

    int n_pass = 0;
    int n_total = 0;

    logic [1:0] g_t [0:39];
    logic       c_t [0:39];
    logic       s_t [0:39];
    logic       d_t [0:39];
    logic       a_t [0:39];
    logic       b_t [0:39];

    agc_clk_sched #(.WIDTH(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .div_half_a  (div_half_a),
        .div_half_b  (div_half_b),
        .burst_len_a (burst_len_a),
        .burst_len_b (burst_len_b),
        .abort       (abort),
        .gnt         (gnt),
        .clk_out     (clk_out),
        .csgo        (csgo),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int k);
        g_t[k] = gnt;
        c_t[k] = clk_out;
        s_t[k] = csgo;
        d_t[k] = done;
        a_t[k] = aborted;
        b_t[k] = busy;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && busy; i++) tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s_idle_timeout busy=%b want 0", tag, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 2'b11;
        tick();
        tick();
        n_total++; if (gnt !== 2'b00) $display("FAIL rst_gnt got %b want 00", gnt); else n_pass++;
        n_total++; if (clk_out !== 1'b0) $display("FAIL rst_clk_out got %b want 0", clk_out); else n_pass++;
        n_total++; if (csgo !== 1'b0) $display("FAIL rst_csgo got %b want 0", csgo); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
        n_total++; if (aborted !== 1'b0) $display("FAIL rst_aborted got %b want 0", aborted); else n_pass++;
        req = 2'b00;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int gcnt, errs, scnt, dcnt, rises;
        logic exp_c;
        div_half_a = 8'd2;
        burst_len_a = 8'd3;
        req = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            tick();
            capture(k);
            if (k == 1) req = 2'b00;
            if (k == 2) begin
                div_half_a = 8'd5;
                burst_len_a = 8'd9;
            end
            if (k == 15) abort = 1'b1;
            if (k == 16) abort = 1'b0;
        end
        gcnt = 0; errs = 0; scnt = 0; dcnt = 0; rises = 0;
        for (int k = 1; k <= 20; k++) begin
            exp_c = (k >= 4) && (k <= 13) && ((((k - 4) / 2) % 2) == 0);
            if (g_t[k] === 2'b01) gcnt++;
            if (c_t[k] !== exp_c) errs++;
            if (s_t[k] === 1'b1) scnt++;
            if (d_t[k] === 1'b1) dcnt++;
            if (k > 1 && c_t[k] === 1'b1 && c_t[k-1] === 1'b0) rises++;
        end
        n_total++; if (gcnt != 15) $display("FAIL basic_gnt_cycles got %0d want 15", gcnt); else n_pass++;
        n_total++; if (g_t[16] !== 2'b00) $display("FAIL basic_gnt_clear got %b want 00", g_t[16]); else n_pass++;
        n_total++; if (errs != 0) $display("FAIL basic_clk_pattern got %0d wrong cycles want 0", errs); else n_pass++;
        n_total++; if (rises != 3) $display("FAIL basic_pulses got %0d want 3", rises); else n_pass++;
        n_total++; if (scnt != 1 || s_t[4] !== 1'b1) $display("FAIL basic_csgo got count %0d at4=%b want 1/1", scnt, s_t[4]); else n_pass++;
        n_total++; if (d_t[15] !== 1'b1 || dcnt != 1) $display("FAIL basic_done got at15=%b count %0d want 1/1", d_t[15], dcnt); else n_pass++;
        n_total++; if (a_t[15] !== 1'b0) $display("FAIL basic_aborted got %b want 0", a_t[15]); else n_pass++;
        n_total++; if (b_t[15] !== 1'b1 || b_t[16] !== 1'b0) $display("FAIL basic_busy got %b%b want 10", b_t[15], b_t[16]); else n_pass++;
        n_total++; if (a_t[16] !== 1'b0 || d_t[16] !== 1'b0) $display("FAIL basic_abort_in_done got a=%b d=%b want 0/0", a_t[16], d_t[16]); else n_pass++;
        wait_idle("basic");
    endtask

    task automatic test_round_robin();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        div_half_a = 8'd1; burst_len_a = 8'd1;
        div_half_b = 8'd1; burst_len_b = 8'd1;
        req = 2'b11;
        for (int k = 1; k <= 14; k++) begin
            tick();
            capture(k);
        end
        req = 2'b00;
        n_total++; if (g_t[1] !== 2'b01) $display("FAIL rr_first got %b want 01", g_t[1]); else n_pass++;
        n_total++; if (d_t[5] !== 1'b1 || g_t[6] !== 2'b00) $display("FAIL rr_first_end got done=%b gnt=%b want 1/00", d_t[5], g_t[6]); else n_pass++;
        n_total++; if (g_t[7] !== 2'b10) $display("FAIL rr_second got %b want 10", g_t[7]); else n_pass++;
        n_total++; if (g_t[13] !== 2'b01) $display("FAIL rr_third got %b want 01", g_t[13]); else n_pass++;
        wait_idle("rr");
    endtask

    task automatic test_zero_len();
        int ccnt, scnt, dcnt;
        div_half_b = 8'd3;
        burst_len_b = 8'd0;
        req = 2'b10;
        for (int k = 1; k <= 6; k++) begin
            tick();
            capture(k);
            if (k == 1) req = 2'b00;
        end
        ccnt = 0; scnt = 0; dcnt = 0;
        for (int k = 1; k <= 6; k++) begin
            if (c_t[k] !== 1'b0) ccnt++;
            if (s_t[k] !== 1'b0) scnt++;
            if (d_t[k] === 1'b1) dcnt++;
        end
        n_total++; if (g_t[1] !== 2'b10) $display("FAIL zero_gnt got %b want 10", g_t[1]); else n_pass++;
        n_total++; if (d_t[2] !== 1'b1 || dcnt != 1) $display("FAIL zero_done got at2=%b count %0d want 1/1", d_t[2], dcnt); else n_pass++;
        n_total++; if (a_t[2] !== 1'b0) $display("FAIL zero_aborted got %b want 0", a_t[2]); else n_pass++;
        n_total++; if (ccnt != 0) $display("FAIL zero_clk_out got %0d high cycles want 0", ccnt); else n_pass++;
        n_total++; if (scnt != 0) $display("FAIL zero_csgo got %0d pulses want 0", scnt); else n_pass++;
        n_total++; if (g_t[3] !== 2'b00) $display("FAIL zero_gnt_clear got %b want 00", g_t[3]); else n_pass++;
        wait_idle("zero");
    endtask

    task automatic test_abort();
        int dcnt;
        div_half_a = 8'd3;
        burst_len_a = 8'd4;
        req = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            tick();
            capture(k);
            if (k == 1) req = 2'b00;
            if (k == 6) abort = 1'b1;
            if (k == 7) abort = 1'b0;
        end
        dcnt = 0;
        for (int k = 1; k <= 10; k++) if (d_t[k] === 1'b1) dcnt++;
        n_total++; if (c_t[6] !== 1'b1) $display("FAIL abort_pre_clk got %b want 1", c_t[6]); else n_pass++;
        n_total++; if (c_t[7] !== 1'b0) $display("FAIL abort_clk_low got %b want 0", c_t[7]); else n_pass++;
        n_total++; if (d_t[7] !== 1'b1 || a_t[7] !== 1'b1) $display("FAIL abort_done got d=%b a=%b want 1/1", d_t[7], a_t[7]); else n_pass++;
        n_total++; if (g_t[7] !== 2'b01) $display("FAIL abort_gnt_hold got %b want 01", g_t[7]); else n_pass++;
        n_total++; if (dcnt != 1 || b_t[8] !== 1'b0) $display("FAIL abort_end got dones %0d busy %b want 1/0", dcnt, b_t[8]); else n_pass++;
        wait_idle("abort");
    endtask

    task automatic test_abort_final();
        div_half_a = 8'd1;
        burst_len_a = 8'd1;
        req = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            tick();
            capture(k);
            if (k == 1) req = 2'b00;
            if (k == 3) abort = 1'b1;
            if (k == 4) abort = 1'b0;
        end
        n_total++; if (c_t[3] !== 1'b1 || s_t[3] !== 1'b1) $display("FAIL absfin_rise got clk=%b csgo=%b want 1/1", c_t[3], s_t[3]); else n_pass++;
        n_total++; if (d_t[4] !== 1'b1 || a_t[4] !== 1'b1) $display("FAIL absfin_done got d=%b a=%b want 1/1", d_t[4], a_t[4]); else n_pass++;
        n_total++; if (c_t[4] !== 1'b0 || d_t[5] !== 1'b0) $display("FAIL absfin_after got clk=%b d5=%b want 0/0", c_t[4], d_t[5]); else n_pass++;
        wait_idle("absfin");
    endtask

    task automatic test_div_zero();
        int errs, scnt, dcnt;
        logic exp_c;
        div_half_a = 8'd0;
        burst_len_a = 8'd2;
        req = 2'b01;
        for (int k = 1; k <= 9; k++) begin
            tick();
            capture(k);
            if (k == 1) req = 2'b00;
        end
        errs = 0; scnt = 0; dcnt = 0;
        for (int k = 1; k <= 9; k++) begin
            exp_c = (k == 3) || (k == 5);
            if (c_t[k] !== exp_c) errs++;
            if (s_t[k] === 1'b1) scnt++;
            if (d_t[k] === 1'b1) dcnt++;
        end
        n_total++; if (errs != 0) $display("FAIL div0_clk_pattern got %0d wrong cycles want 0", errs); else n_pass++;
        n_total++; if (scnt != 1 || s_t[3] !== 1'b1) $display("FAIL div0_csgo got count %0d at3=%b want 1/1", scnt, s_t[3]); else n_pass++;
        n_total++; if (d_t[7] !== 1'b1 || dcnt != 1) $display("FAIL div0_done got at7=%b count %0d want 1/1", d_t[7], dcnt); else n_pass++;
        wait_idle("div0");
    endtask

    task automatic test_reset_mid();
        div_half_a = 8'd2;
        burst_len_a = 8'd3;
        req = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            tick();
            capture(k);
            if (k == 1) req = 2'b00;
        end
        n_total++; if (c_t[5] !== 1'b1) $display("FAIL rmid_pre_clk got %b want 1", c_t[5]); else n_pass++;
        rst = 1'b0;
        tick();
        n_total++; if (gnt !== 2'b00 || clk_out !== 1'b0 || csgo !== 1'b0) $display("FAIL rmid_outputs got gnt=%b clk=%b csgo=%b want 00/0/0", gnt, clk_out, csgo); else n_pass++;
        n_total++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) $display("FAIL rmid_flags got busy=%b done=%b ab=%b want 0/0/0", busy, done, aborted); else n_pass++;
        rst = 1'b1;
        req = 2'b11;
        tick();
        req = 2'b00;
        n_total++; if (gnt !== 2'b01) $display("FAIL rmid_regrant got %b want 01", gnt); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rmid_no_done got %b want 0", done); else n_pass++;
        wait_idle("rmid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_zero_len();
        test_abort();
        test_abort_final();
        test_div_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
